pc_redirect_unit: RTL and testbench
===================================

# pc_redirect_unit

Sequential program-counter update unit for the single-cycle/pipelined CPU datapath. It consumes jump, branch and register-jump requests, forms the 32-bit target, and holds the PC under stall. On a jump it rebuilds the target from the 26-bit instruction index and the upper PC bits. A one-entry pending buffer keeps a redirect that arrives during a stall, so no control transfer is lost.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  synchronous, active-low reset
- stall_i  input  1  hold PC this cycle
- jump_i  input  1  J-type jump request
- jump_idx_i  input  26  instruction index field of J-type instruction
- branch_i  input  1  taken-branch request
- branch_off_i  input  32  sign-extended word offset (not yet shifted)
- jr_i  input  1  register-jump request
- jr_addr_i  input  32  register-jump target address
- pc_o  output  32  current PC (registered)
- pc_plus4_o  output  32  pc_o + 4, combinational from pc_o
- redirect_o  output  1  registered; high for one cycle when pc_o was loaded from a redirect target
- misalign_o  output  1  registered; high for one cycle when an applied jr target had [1:0] != 0

## Operation
- Request priority when multiple request lines are high in one cycle: jr_i > jump_i > branch_i. Lower-priority requests that cycle are dropped.
- Target formation:
  - All sums are modulo 2^32 and use pc_plus4_o sampled in the request cycle.
  - Jump: {pc_plus4_o[31:28], jump_idx_i, 2'b00}.
  - Branch: pc_plus4_o + (branch_off_i << 2), with bits shifted out discarded.
  - jr: {jr_addr_i[31:2], 2'b00}. A misaligned jr sets the pending/applied misalign flag.
- States:
  - RUN: no pending redirect.
  - PEND: pending register holds a target and a misalign flag.
- Transitions and next-PC behaviour:
  - RUN, stall_i=0, request present: pc_o <= target; redirect_o <= 1; misalign_o <= flag.
  - RUN, stall_i=0, no request: pc_o <= pc_o + 4; redirect_o <= 0; misalign_o <= 0.
  - RUN, stall_i=1, request present: pc_o holds. Capture target and flag. Go to PEND.
  - RUN, stall_i=1, no request: pc_o holds; outputs pulse 0.
  - PEND, stall_i=1: pc_o holds. A new request overwrites the pending target and flag (newest wins). Stay in PEND.
  - PEND, stall_i=0: pc_o <= new request's target if a request is present, otherwise the pending target. redirect_o <= 1. Go to RUN.
- Wrap-around: pc_o = 32'hFFFF_FFFC with no request advances to 32'h0000_0000.

## Timing
- Reset (rst_i=0 at a rising edge):
  - pc_o = RESET_PC; redirect_o = 0; misalign_o = 0; state = RUN; pending cleared.
  - Reset overrides stall_i and all requests in the same cycle.
  - Reset during PEND discards the pending target.
- Latency:
  - Request accepted in cycle n with no stall: target visible on pc_o in cycle n+1, with redirect_o=1 in n+1 only.
  - Stalled request: target appears in the cycle after the first cycle with stall_i=0.
- pc_plus4_o tracks pc_o with zero-cycle latency.
- redirect_o and misalign_o are never high for more than one consecutive cycle unless back-to-back redirects are applied.

## Test plan
- Reset and sequential step: hold rst_i=0 for 2 cycles, then release with RESET_PC=0 and no requests → pc_o = 0, 4, 8, 12. Both pulse outputs stay 0.
- Jump target formation: pc_o=32'h4000_0010, jump_i=1, jump_idx_i=26'h000_0040 → next pc_o=32'h4000_0100 with redirect_o=1 for exactly one cycle.
- Negative branch and priority:
  - pc_o=32'h0000_0020, branch_i=1, branch_off_i=32'hFFFF_FFFE → pc_o=32'h0000_001C.
  - Same cycle with jr_i=1, jr_addr_i=32'h0000_0200 → pc_o=32'h0000_0200.
- Misaligned jr: jr_addr_i=32'h0000_0103 → pc_o=32'h0000_0100 with misalign_o=1 and redirect_o=1 for one cycle.
- Stall with pending:
  - pc_o=32'h0000_0008; stall_i=1 for 3 cycles; jump to index 26'h10 in the first stall cycle and branch off 32'h1 in the second → pc_o holds 8.
  - After stall_i drops, pc_o=32'h0000_0010 (the branch target, newest wins).
- Wrap and reset mid-pending:
  - pc_o=32'hFFFF_FFFC with no request → pc_o=0.
  - Separately, enter PEND and then assert rst_i=0 → pc_o=RESET_PC, and no redirect is applied after release.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// PC update unit: sequential step, jump/branch/jr redirects with priority,
// and a one-entry pending buffer that holds a redirect requested under stall.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [25:0] jump_idx_i,
  input  logic        branch_i,
  input  logic [31:0] branch_off_i,
  input  logic        jr_i,
  input  logic [31:0] jr_addr_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        redirect_o,
  output logic        misalign_o
);

  typedef enum logic {RUN, PEND} state_e;

  typedef struct packed {
    logic        mis;
    logic [31:0] tgt;
  } redir_t;

  state_e      state_q, state_d;
  redir_t      req, pend_q, pend_d, sel;
  logic        req_vld;
  logic [31:0] pc_d;
  logic        redirect_d, misalign_d;

  assign pc_plus4_o = pc_o + 32'd4;

  // Highest-priority request wins; lower ones in the same cycle are dropped.
  always_comb begin : req_sel
    req_vld = 1'b0;
    req     = '0;
    if (jr_i) begin
      req_vld = 1'b1;
      req.mis = |jr_addr_i[1:0];
      req.tgt = {jr_addr_i[31:2], 2'b00};
    end else if (jump_i) begin
      req_vld = 1'b1;
      req.tgt = {pc_plus4_o[31:28], jump_idx_i, 2'b00};
    end else if (branch_i) begin
      req_vld = 1'b1;
      req.tgt = pc_plus4_o + (branch_off_i << 2);
    end
  end

  always_comb begin : next_state
    state_d    = state_q;
    pend_d     = pend_q;
    pc_d       = pc_o;
    redirect_d = 1'b0;
    misalign_d = 1'b0;
    sel        = req_vld ? req : pend_q;
    case (state_q)
      RUN: begin
        if (stall_i) begin
          if (req_vld) begin
            pend_d  = req;
            state_d = PEND;
          end
        end else if (req_vld) begin
          pc_d       = req.tgt;
          redirect_d = 1'b1;
          misalign_d = req.mis;
        end else begin
          pc_d = pc_plus4_o;
        end
      end
      PEND: begin
        if (stall_i) begin
          // Newest request replaces whatever is parked.
          if (req_vld) pend_d = req;
        end else begin
          pc_d       = sel.tgt;
          redirect_d = 1'b1;
          misalign_d = sel.mis;
          pend_d     = '0;
          state_d    = RUN;
        end
      end
      default: begin
        state_d = RUN;
        pend_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= RUN;
      pend_q     <= '0;
      pc_o       <= RESET_PC;
      redirect_o <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pc_o       <= pc_d;
      redirect_o <= redirect_d;
      misalign_o <= misalign_d;
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: driver pushes model predictions,
// a monitor pops and compares after every rising edge.
module tb_pc_redirect_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, jump, branch, jr;
  logic [25:0] jump_idx;
  logic [31:0] branch_off, jr_addr;
  logic [31:0] pc, pc_plus4;
  logic        redirect, misalign;

  pc_redirect_unit #(.RESET_PC(RST_PC)) dut (
    .clk_i(clk), .rst_i(rst_n), .stall_i(stall),
    .jump_i(jump), .jump_idx_i(jump_idx),
    .branch_i(branch), .branch_off_i(branch_off),
    .jr_i(jr), .jr_addr_i(jr_addr),
    .pc_o(pc), .pc_plus4_o(pc_plus4),
    .redirect_o(redirect), .misalign_o(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        red;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference state: architectural PC plus an optional parked redirect.
  logic [31:0] m_pc = RST_PC;
  bit          m_has_pend = 0;
  logic [31:0] m_pend_tgt = '0;
  bit          m_pend_mis = 0;

  task automatic step(input bit r_n, input bit st,
                      input bit j, input logic [25:0] idx,
                      input bit b, input logic [31:0] off,
                      input bit rj, input logic [31:0] addr);
    exp_t        e;
    bit          have;
    logic [31:0] t, nxt;
    bit          f;
    @(negedge clk); #1;
    rst_n = r_n; stall = st; jump = j; jump_idx = idx;
    branch = b; branch_off = off; jr = rj; jr_addr = addr;
    nxt = m_pc + 32'd4;
    have = 1; f = 0; t = '0;
    if (rj)     begin t = addr & 32'hFFFF_FFFC; f = (addr % 4) != 0; end
    else if (j) t = {nxt[31:28], idx, 2'b00};
    else if (b) t = nxt + off * 32'd4;
    else        have = 0;
    e.red = 0; e.mis = 0;
    if (!r_n) begin
      m_pc = RST_PC; m_has_pend = 0;
    end else if (st) begin
      if (have) begin m_has_pend = 1; m_pend_tgt = t; m_pend_mis = f; end
    end else if (have) begin
      m_pc = t; e.red = 1; e.mis = f; m_has_pend = 0;
    end else if (m_has_pend) begin
      m_pc = m_pend_tgt; e.red = 1; e.mis = m_pend_mis; m_has_pend = 0;
    end else begin
      m_pc = nxt;
    end
    e.pc = m_pc;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, '0, 0, '0, 0, '0);
  endtask

  task automatic do_jr(input logic [31:0] a);
    step(1, 0, 0, '0, 0, '0, 1, a);
  endtask

  initial begin : monitor
    exp_t e;
    bit   bad;
    forever begin
      @(posedge clk); #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        bad = 0;
        if (pc !== e.pc) begin
          bad = 1; $display("FAIL pc: got %h want %h", pc, e.pc);
        end
        if (pc_plus4 !== e.pc + 32'd4) begin
          bad = 1; $display("FAIL pc_plus4: got %h want %h", pc_plus4, e.pc + 32'd4);
        end
        if (redirect !== e.red) begin
          bad = 1; $display("FAIL redirect: got %b want %b (pc %h)", redirect, e.red, e.pc);
        end
        if (misalign !== e.mis) begin
          bad = 1; $display("FAIL misalign: got %b want %b (pc %h)", misalign, e.mis, e.pc);
        end
        if (bad) miscompares++;
      end
    end
  end

  initial begin : driver
    rst_n = 0; stall = 0; jump = 0; jump_idx = '0;
    branch = 0; branch_off = '0; jr = 0; jr_addr = '0;

    // Reset, second cycle with stall and requests that reset must override.
    step(0, 0, 0, '0, 0, '0, 0, '0);
    step(0, 1, 1, 26'h3, 1, 32'h5, 1, 32'h123);
    idle(4);

    // Jump target formation from upper PC bits.
    do_jr(32'h4000_0010);
    step(1, 0, 1, 26'h000_0040, 0, '0, 0, '0);
    idle(2);

    // Negative branch, then same cycle with jr taking priority.
    do_jr(32'h0000_0020);
    step(1, 0, 0, '0, 1, 32'hFFFF_FFFE, 0, '0);
    do_jr(32'h0000_0020);
    step(1, 0, 1, 26'h55, 1, 32'hFFFF_FFFE, 1, 32'h0000_0200);
    idle(1);

    // Misaligned jr.
    do_jr(32'h0000_0103);
    idle(2);

    // Stall with pending: newest request wins.
    do_jr(32'h0000_0008);
    step(1, 1, 1, 26'h10, 0, '0, 0, '0);
    step(1, 1, 0, '0, 1, 32'h1, 0, '0);
    step(1, 1, 0, '0, 0, '0, 0, '0);
    idle(2);

    // Pending released by a fresh request in the unstall cycle.
    step(1, 1, 1, 26'h20, 0, '0, 0, '0);
    step(1, 0, 0, '0, 0, '0, 1, 32'h0000_0301);
    idle(1);

    // Wrap-around.
    do_jr(32'hFFFF_FFFC);
    idle(2);

    // Reset while pending discards the parked target.
    step(1, 1, 1, 26'h77, 0, '0, 0, '0);
    step(0, 1, 0, '0, 0, '0, 0, '0);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] off;
      off = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($signed($urandom_range(0, 64)) - 32);
      step($urandom_range(0, 63) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, 26'($urandom()),
           $urandom_range(0, 3) == 0, off,
           $urandom_range(0, 4) == 0, $urandom());
    end

    repeat (4) @(posedge clk);
    #4;
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d pending entries want 0", q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
